// File: rtl/result_uart_pkg.sv
// Shared types and helpers for the Result observer UART (state encoding, ASCII hex mapping).
// Pure definitions; no timing or flow control of its own.
package result_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FWFT word FIFO: a push into a full FIFO is accepted only when a pop happens on the same edge.
// Read data is combinational from the head slot; count/pointers update on the clock edge.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_push_dat,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_pop_dat,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_accept,
  output logic               o_drop,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_accept  = w_do_push;
  assign o_drop    = i_push && !w_do_push;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/result_uart.sv
// Logs every change of Result through a FIFO onto an 8N1 UART (raw LSB-first bytes, or ASCII hex + LF with RESULT_UART_HEX_EN).
// Push on the change edge, pop one edge later; no back-pressure to the core, a full FIFO drops the change and sets sticky Overflow.
module result_uart
  import result_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       Result,
  output logic                        tx,
  output logic                        Busy,
  output logic                        Overflow,
  output logic [$clog2(FIFO_DEPTH):0] Count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef RESULT_UART_HEX_EN
  localparam int NIBS    = DATA_WIDTH / 4;
  localparam int NFRAMES = NIBS + 1;
`else
  localparam int NFRAMES = DATA_WIDTH / 8;
`endif
  localparam int BIW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIW-1:0] LAST_FRAME = BIW'(NFRAMES - 1);
  localparam logic [BCW-1:0] LAST_CLK   = BCW'(CLKS_PER_BIT - 1);

  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_overflow;
  logic                  r_busy;
  logic                  r_tx;
  uart_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [BIW-1:0]        r_byte_idx;
  logic [2:0]            r_bit_idx;
  logic [BCW-1:0]        r_clk_cnt;

  uart_state_t           w_state_nxt;
  logic [DATA_WIDTH-1:0] w_word_nxt;
  logic [BIW-1:0]        w_byte_nxt;
  logic [2:0]            w_bit_nxt;
  logic [BCW-1:0]        w_clk_nxt;
  logic                  w_tx_nxt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_empty;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_fifo_dat;
  logic [CW-1:0]         w_count;
  logic [7:0]            w_frame;

  function automatic logic [7:0] frame_byte(input logic [DATA_WIDTH-1:0] word,
                                            input logic [BIW-1:0] idx);
`ifdef RESULT_UART_HEX_EN
    if (idx == LAST_FRAME) return NEWLINE_CHAR;
    return nib2ascii(4'(word >> (4 * (NIBS - 1 - int'(idx)))));
`else
    return 8'(word >> (8 * int'(idx)));
`endif
  endfunction

  assign w_push = (Result != r_prev);

  result_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push     (w_push),
    .i_push_dat (Result),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_accept   (w_accept),
    .o_drop     (w_drop),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_prev <= Result;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_byte_nxt  = r_byte_idx;
    w_bit_nxt   = r_bit_idx;
    w_clk_nxt   = r_clk_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_word_nxt  = w_fifo_dat;
          w_byte_nxt  = '0;
          w_bit_nxt   = '0;
          w_clk_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_clk_cnt == LAST_CLK) begin
          w_clk_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_clk_nxt = r_clk_cnt + BCW'(1);
        end
      end
      DATA: begin
        if (r_clk_cnt == LAST_CLK) begin
          w_clk_nxt = '0;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit_idx + 3'd1;
        end else begin
          w_clk_nxt = r_clk_cnt + BCW'(1);
        end
      end
      STOP: begin
        if (r_clk_cnt == LAST_CLK) begin
          w_clk_nxt = '0;
          if (r_byte_idx == LAST_FRAME) begin
            w_state_nxt = IDLE;
          end else begin
            w_byte_nxt  = r_byte_idx + BIW'(1);
            w_state_nxt = START;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + BCW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line level is decided from next-state values so tx itself can be a flop.
  assign w_frame = frame_byte(w_word_nxt, w_byte_nxt);

  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_frame[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_clk_cnt  <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_byte_idx <= w_byte_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_clk_cnt  <= w_clk_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_accept || (w_count > CW'(w_pop)) || (w_state_nxt != IDLE);
    end
  end

  assign tx       = r_tx;
  assign Busy     = r_busy;
  assign Overflow = r_overflow;
  assign Count    = w_count;

endmodule
